// File: rtl/axis_bram_writer_if.sv
// rtl/axis_bram_writer_if.sv - AXI-Stream beat channel feeding the BRAM writer
interface axis_bram_writer_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_bram_writer.sv
// rtl/axis_bram_writer.sv - one word per accepted AXI-Stream beat into BRAM port B, armed by cfg_start
// Optional macro AXIS_BRAM_WRITER_WRAP_EN: circular capture with a 1-cycle sts_done pulse per pass.
module axis_bram_writer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                         i_aclk,
  input  logic                         i_areset,
  input  logic                         i_cfg_start,
  input  logic [BRAM_ADDR_WIDTH-1:0]   i_cfg_last,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_sts_addr,
  output logic                         o_sts_done,
  axis_bram_writer_if.slave            s_axis,
  output logic                         o_bram_portb_clk,
  output logic                         o_bram_portb_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_bram_portb_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   o_bram_portb_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] o_bram_portb_we
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

  state_t                         r_state;
  logic                           r_start_q;
  logic [BRAM_ADDR_WIDTH-1:0]     r_sts_addr;
  logic                           r_sts_done;
  logic [BRAM_ADDR_WIDTH-1:0]     r_addr;
  logic [BRAM_DATA_WIDTH-1:0]     r_wrdata;
  logic [BRAM_DATA_WIDTH/8-1:0]   r_we;

  logic w_rise;
  logic w_ready;
  logic w_accept;
  logic w_at_last;

  assign w_rise    = i_cfg_start & ~r_start_q;
  // Dropping cfg_start removes tready in the same cycle so an abort never writes.
  assign w_ready   = (r_state == S_FILL) & i_cfg_start;
  assign w_accept  = s_axis.tvalid & w_ready;
  assign w_at_last = (r_sts_addr == i_cfg_last);

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_sts_addr <= '0;
      r_sts_done <= 1'b0;
      r_addr     <= '0;
      r_wrdata   <= '0;
      r_we       <= '0;
    end else begin
      r_start_q <= i_cfg_start;
      r_we      <= '0;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
      r_sts_done <= 1'b0;
`endif
      if (w_accept) begin
        r_addr   <= r_sts_addr;
        r_wrdata <= s_axis.tdata[BRAM_DATA_WIDTH-1:0];
        r_we     <= '1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state    <= S_FILL;
            r_sts_addr <= '0;
            r_sts_done <= 1'b0;
          end
        end
        S_FILL: begin
          if (!i_cfg_start) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            if (w_at_last) begin
`ifdef AXIS_BRAM_WRITER_WRAP_EN
              r_sts_addr <= '0;
              r_sts_done <= 1'b1;
`else
              r_sts_addr <= r_sts_addr + ADDR_ONE;
              r_sts_done <= 1'b1;
              r_state    <= S_DONE;
`endif
            end else begin
              r_sts_addr <= r_sts_addr + ADDR_ONE;
            end
          end
        end
        S_DONE: begin
          if (!i_cfg_start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis.tready       = w_ready;
  assign o_sts_addr          = r_sts_addr;
  assign o_sts_done          = r_sts_done;
  assign o_bram_portb_clk    = i_aclk;
  assign o_bram_portb_rst    = i_areset;
  assign o_bram_portb_addr   = r_addr;
  assign o_bram_portb_wrdata = r_wrdata;
  assign o_bram_portb_we     = r_we;

endmodule
